// File: rtl/regs_watch_scanner.sv
// regs_watch_scanner: sweeps the register file watch port over
// [FIRST_REG, LAST_REG] and presents each captured value as a tagged
// valid/ready beat. Supports one-shot sweeps and wrap-around scanning
// with a programmable idle dwell after every accepted beat.
module regs_watch_scanner #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter int DWELL     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        autoScan,
  input  logic        stop,
  output logic [4:0]  regWatchNum,
  input  logic [31:0] regWatchData,
  output logic        outValid,
  input  logic        outReady,
  output logic [4:0]  outNum,
  output logic [31:0] outData,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0]  FIRST_IDX    = 5'(FIRST_REG);
  localparam logic [4:0]  LAST_IDX     = 5'(LAST_REG);
  localparam logic [15:0] DWELL_LEN    = 16'(DWELL);
  localparam logic [15:0] DWELL_RELOAD = DWELL_LEN - 16'd1;
  localparam logic        HAS_DWELL    = (DWELL_LEN != 16'd0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  index_r;
  logic [15:0] dwell_cnt_r;
  logic        accept_s;
  logic [4:0]  index_inc_s;

  // Beat handshake and the 5-bit wrapping successor of the current index.
  always_comb begin
    accept_s    = outValid && outReady;
    index_inc_s = index_r + 5'd1;
  end

  // Scanner FSM; regWatchNum is updated together with index so that it
  // already shows the next register when LOAD is entered (0 while idle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      index_r     <= FIRST_IDX;
      dwell_cnt_r <= 16'd0;
      regWatchNum <= 5'd0;
      outValid    <= 1'b0;
      outNum      <= 5'd0;
      outData     <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            index_r     <= FIRST_IDX;
            regWatchNum <= FIRST_IDX;
            busy        <= 1'b1;
            state_r     <= LOAD;
          end
        end
        LOAD: begin
          // Capture edge: any negedge write during LOAD is already visible.
          outData  <= regWatchData;
          outNum   <= index_r;
          outValid <= 1'b1;
          state_r  <= SEND;
        end
        SEND: begin
          if (accept_s) begin
            outValid <= 1'b0;
            if (stop) begin
              regWatchNum <= 5'd0;
              busy        <= 1'b0;
              state_r     <= IDLE;
            end else if (index_r == LAST_IDX) begin
              done <= 1'b1;
              if (autoScan) begin
                index_r     <= FIRST_IDX;
                regWatchNum <= FIRST_IDX;
                if (HAS_DWELL) begin
                  dwell_cnt_r <= DWELL_RELOAD;
                  state_r     <= GAP;
                end else begin
                  state_r <= LOAD;
                end
              end else begin
                regWatchNum <= 5'd0;
                busy        <= 1'b0;
                state_r     <= IDLE;
              end
            end else begin
              index_r     <= index_inc_s;
              regWatchNum <= index_inc_s;
              if (HAS_DWELL) begin
                dwell_cnt_r <= DWELL_RELOAD;
                state_r     <= GAP;
              end else begin
                state_r <= LOAD;
              end
            end
          end
        end
        GAP: begin
          if (stop) begin
            regWatchNum <= 5'd0;
            busy        <= 1'b0;
            dwell_cnt_r <= 16'd0;
            state_r     <= IDLE;
          end else if (dwell_cnt_r == 16'd0) begin
            state_r <= LOAD;
          end else begin
            dwell_cnt_r <= dwell_cnt_r - 16'd1;
          end
        end
        default: begin
          regWatchNum <= 5'd0;
          outValid    <= 1'b0;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
